// File: rtl/gray_window_3x3_if.sv
// Pixel stream bundle between the grayscale stage, the 3x3 window generator
// and the downstream matching stages.
//   i_FVAL / i_DVAL / i_gray : frame valid, pixel valid, gray pixel into the window
//   o_DVAL / o_win           : window valid and 3x3 window out (top-left in the MSBs)
//   o_col / o_row            : window-centre coordinates, present only when
//                              GRAY_WINDOW_POS_OUT_EN is defined
// slave modport is the window generator; master is the side that feeds it pixels
// and reads windows back.
interface gray_window_3x3_if #(
    parameter int DATA_W = 8
`ifdef GRAY_WINDOW_POS_OUT_EN
    ,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
`endif
);
    logic                  i_FVAL;
    logic                  i_DVAL;
    logic [DATA_W-1:0]     i_gray;
    logic                  o_DVAL;
    logic [9*DATA_W-1:0]   o_win;
`ifdef GRAY_WINDOW_POS_OUT_EN
    logic [$clog2(IMG_WIDTH)-1:0]  o_col;
    logic [$clog2(IMG_HEIGHT)-1:0] o_row;
`endif

    modport slave (
        input  i_FVAL, i_DVAL, i_gray,
`ifdef GRAY_WINDOW_POS_OUT_EN
        output o_col, o_row,
`endif
        output o_DVAL, o_win
    );

    modport master (
        output i_FVAL, i_DVAL, i_gray,
`ifdef GRAY_WINDOW_POS_OUT_EN
        input  o_col, o_row,
`endif
        input  o_DVAL, o_win
    );
endinterface

// File: rtl/gray_window_3x3.sv
// Raster-order line buffer and 3x3 window generator.
// Keeps the two previous lines in on-chip buffers and, for every accepted
// pixel, shifts a new {top, mid, bot} column into a registered 3x3 window.
// o_DVAL marks windows that lie fully inside the frame (centre at row-1, col-1).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : gray_window_3x3_if.slave (pixel stream in, window stream out)
// Optional: define GRAY_WINDOW_POS_OUT_EN to add registered window-centre
// coordinates (o_col, o_row) to the interface.
module gray_window_3x3 #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    gray_window_3x3_if.slave  bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic              acc;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] lb1 [IMG_WIDTH];
    logic [DATA_W-1:0] lb2 [IMG_WIDTH];
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] mid;
    logic [DATA_W-1:0] win [3][3];
    logic              dval;
    logic              inner;

    assign acc   = bus.i_FVAL & bus.i_DVAL;
    assign top   = lb2[col];
    assign mid   = lb1[col];
    // Only windows whose newest pixel is at row>=2, col>=2 are fully inside the
    // current frame; everything else may carry stale line-buffer data.
    assign inner = (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (!bus.i_FVAL) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers are plain RAM: no reset, read-before-write at the same column.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb2[col] <= lb1[col];
            lb1[col] <= bus.i_gray;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dval <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            dval <= acc & inner;
            if (acc) begin
                for (int r = 0; r < 3; r++) begin
                    win[r][0] <= win[r][1];
                    win[r][1] <= win[r][2];
                end
                win[0][2] <= top;
                win[1][2] <= mid;
                win[2][2] <= bus.i_gray;
            end
        end
    end

    assign bus.o_DVAL = dval;

    // Row-major flatten: win[0][0] (top-left) lands in the MSBs.
    always_comb begin
        bus.o_win = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                bus.o_win[(8 - (r * 3 + c)) * DATA_W +: DATA_W] = win[r][c];
            end
        end
    end

`ifdef GRAY_WINDOW_POS_OUT_EN
    logic [CW-1:0] pos_col;
    logic [RW-1:0] pos_row;

    // Updated only alongside a valid window so the coordinates hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_col <= '0;
            pos_row <= '0;
        end else if (acc && inner) begin
            pos_col <= col - CW'(1);
            pos_row <= row - RW'(1);
        end
    end

    assign bus.o_col = pos_col;
    assign bus.o_row = pos_row;
`endif
endmodule

// File: tb/tb_gray_window_3x3.sv
module tb_gray_window_3x3;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;

    logic clk;
    logic rst_n;

`ifdef GRAY_WINDOW_POS_OUT_EN
    gray_window_3x3_if #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();
`else
    gray_window_3x3_if #(.DATA_W(DW)) bus ();
`endif

    gray_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the frame as a picture indexed by (row, col).
    logic [DW-1:0] img [H][W];
    int            mr, mc;
    int            exp_col, exp_row;
    int            pulses;
    logic          last_dval;
    logic [71:0]   last_win;
    logic [71:0]   wins [$];

    typedef struct {
        logic        fval;
        logic        dval;
        logic [7:0]  gray;
        logic        exp_dval;
        logic [71:0] exp_win;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mr = 0; mc = 0; exp_col = 0; exp_row = 0;
    endtask

    // Drive one cycle, predict from the picture model, then compare after the edge.
    task automatic step(input logic fv, input logic dv, input logic [7:0] g);
        logic        ev;
        logic [71:0] ew;
        bus.i_FVAL = fv;
        bus.i_DVAL = dv;
        bus.i_gray = g;
        ev = 1'b0;
        ew = '0;
        if (!fv) begin
            mr = 0; mc = 0;
        end else if (dv) begin
            img[mr][mc] = g;
            if (mr >= 2 && mc >= 2) begin
                ev = 1'b1;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        ew = (ew << 8) | 72'(img[mr-2+rr][mc-2+cc]);
                exp_col = mc - 1;
                exp_row = mr - 1;
            end
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc++;
            end
        end
        @(posedge clk);
        #1;
        check("o_dval", 72'(bus.o_DVAL), 72'(ev));
        if (ev) check("o_win", bus.o_win, ew);
`ifdef GRAY_WINDOW_POS_OUT_EN
        check("o_col", 72'(bus.o_col), 72'(exp_col));
        check("o_row", 72'(bus.o_row), 72'(exp_row));
`endif
        last_dval = bus.o_DVAL;
        last_win  = bus.o_win;
        if (bus.o_DVAL) begin
            pulses++;
            wins.push_back(bus.o_win);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_FVAL = 1'b0;
        bus.i_DVAL = 1'b0;
        bus.i_gray = '0;
        model_reset();
        #12;
        check("reset_dval", 72'(bus.o_DVAL), 72'd0);
        check("reset_win", bus.o_win, 72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table: 4x3 frame, pixel = row*16+col, continuous.
        for (int i = 0; i < 12; i++) begin
            tbl[i].fval     = 1'b1;
            tbl[i].dval     = 1'b1;
            tbl[i].gray     = 8'(((i / W) * 16) + (i % W));
            tbl[i].exp_dval = (i == 10) || (i == 11);
            tbl[i].exp_win  = '0;
        end
        tbl[10].exp_win = 72'h00_01_02_10_11_12_20_21_22;
        tbl[11].exp_win = 72'h01_02_03_11_12_13_21_22_23;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            bus.i_FVAL = tbl[i].fval;
            bus.i_DVAL = tbl[i].dval;
            bus.i_gray = tbl[i].gray;
            @(posedge clk);
            #1;
            check("tbl_dval", 72'(bus.o_DVAL), 72'(tbl[i].exp_dval));
            if (tbl[i].exp_dval) check("tbl_win", bus.o_win, tbl[i].exp_win);
            if (bus.o_DVAL) pulses++;
        end
        check("tbl_pulses", 72'(pulses), 72'd2);
        step(1'b0, 1'b0, 8'h00);
        check("tbl_idle_dval", 72'(bus.o_DVAL), 72'd0);

        // Same frame with random i_DVAL gaps.
        pulses = 0;
        wins.delete();
        for (int i = 0; i < W * H; i++) begin
            repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 8'h55);
            step(1'b1, 1'b1, 8'(((i / W) * 16) + (i % W)));
        end
        check("gap_pulses", 72'(pulses), 72'd2);
        check("gap_win0", wins[0], 72'h00_01_02_10_11_12_20_21_22);
        check("gap_win1", wins[1], 72'h01_02_03_11_12_13_21_22_23);
        step(1'b0, 1'b0, 8'h00);

        // Frame abandoned after pixel (2,1), then a fresh frame at 0x80 base.
        pulses = 0;
        for (int i = 0; i < 2 * W + 2; i++) step(1'b1, 1'b1, 8'(8'h40 + i));
        step(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 2 * W + 2; i++) step(1'b1, 1'b1, 8'(8'h80 + (i / W) * 16 + (i % W)));
        check("drop_no_early", 72'(pulses), 72'd0);
        step(1'b1, 1'b1, 8'hA2);
        check("drop_first_dval", 72'(last_dval), 72'd1);
        check("drop_first_win", last_win, 72'h80_81_82_90_91_92_A0_A1_A2);
        step(1'b1, 1'b1, 8'hA3);
        step(1'b0, 1'b0, 8'h00);

        // i_DVAL high with i_FVAL low carrying 0xFF, then a normal frame.
        pulses = 0;
        repeat (10) step(1'b0, 1'b1, 8'hFF);
        check("fvlow_pulses", 72'(pulses), 72'd0);
        for (int i = 0; i < W * H; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        check("fvlow_frame_pulses", 72'(pulses), 72'd2);

        // Random stream, then reset mid-stream.
        for (int i = 0; i < 17; i++) step(1'b1, 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dval", 72'(bus.o_DVAL), 72'd0);
        check("arst_win", bus.o_win, 72'd0);
`ifdef GRAY_WINDOW_POS_OUT_EN
        check("arst_col", 72'(bus.o_col), 72'd0);
        check("arst_row", 72'(bus.o_row), 72'd0);
`endif
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulses = 0;
        for (int i = 0; i < 2 * W + 2; i++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        check("post_rst_no_early", 72'(pulses), 72'd0);
        step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
        check("post_rst_first", 72'(last_dval), 72'd1);

        // Long random run with occasional frame drops.
        pulses = 0;
        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 39) != 0), 1'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
